demux_feeder: RTL and testbench

Round-robin bit dispatcher sitting directly upstream of the 1-to-4 `demux`. It accepts a serial bit stream through a valid/ready handshake and assigns each bit to the next enabled output channel. It presents the bit on `d_in` and the channel on `d_sel`, holding both for a programmable number of cycles. Outputs are registered and connect straight to the `demux` ports `d_in` and `d_sel`.

---
 rtl/demux_pkg.sv | 24 ++
 rtl/demux_feeder_if.sv | 24 ++
 rtl/demux_rr_pick.sv | 30 +++
 rtl/demux_feeder.sv | 91 +++++++++
 tb/tb_demux_feeder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared constants, state encoding and output payload for the demux feeder.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned HCNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic             d_valid;
        logic [SEL_W-1:0] d_sel;
        logic             d_in;
    } route_t;

    // Round-robin pointer always moves one past the channel just served.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] ch);
        return ch + SEL_W'(1);
    endfunction

endpackage

// File: rtl/demux_feeder_if.sv
// Upstream bit handshake plus the routed outputs toward the 1-to-4 demux.
interface demux_feeder_if;
    import demux_pkg::*;

    logic [NUM_CH-1:0] en_mask;
    logic              in_valid;
    logic              in_data;
    logic              in_ready;
    logic              d_in;
    logic [SEL_W-1:0]  d_sel;
    logic              d_valid;
    logic              busy;

    modport master (
        output en_mask, in_valid, in_data,
        input  in_ready, d_in, d_sel, d_valid, busy
    );

    modport slave (
        input  en_mask, in_valid, in_data,
        output in_ready, d_in, d_sel, d_valid, busy
    );

endinterface

// File: rtl/demux_rr_pick.sv
// Combinational round-robin channel picker: first enabled channel at or after ptr.
module demux_rr_pick
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  pick,
    output logic              any
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Index arithmetic wraps naturally in SEL_W bits (3 -> 0).
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/demux_feeder.sv
// Round-robin bit dispatcher: routes each accepted bit to the next enabled
// demux channel and holds it on registered outputs for HOLD_CYCLES cycles.
module demux_feeder
    import demux_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    demux_feeder_if.slave  fb
);

    state_e            state_q, state_d;
    route_t            out_q, out_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              busy_q, busy_d;
    logic [SEL_W-1:0]  pick;
    logic              any;
    logic              ready;
    logic              accept;

    demux_rr_pick u_pick (
        .ptr  (ptr_q),
        .mask (fb.en_mask),
        .pick (pick),
        .any  (any)
    );

    // Ready in the last hold cycle lets a new bit follow with no valid gap.
    assign ready  = any & ((state_q == ST_IDLE) | (hcnt_q == '0));
    assign accept = fb.in_valid & ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = (HOLD_CYCLES > 1) ? ST_HOLD : ST_IDLE;
        end else if ((state_q == ST_HOLD) && (hcnt_q == '0)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        out_d  = out_q;
        ptr_d  = ptr_q;
        hcnt_d = hcnt_q;
        if (accept) begin
            out_d.d_in    = fb.in_data;
            out_d.d_sel   = pick;
            out_d.d_valid = 1'b1;
            ptr_d         = next_ptr(pick);
            hcnt_d        = HCNT_W'(HOLD_CYCLES - 1);
        end else if ((state_q == ST_HOLD) && (hcnt_q != '0)) begin
            hcnt_d = hcnt_q - HCNT_W'(1);
        end else begin
            // d_sel keeps its last value once the bit is retired.
            out_d.d_valid = 1'b0;
            out_d.d_in    = 1'b0;
        end
        busy_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            ptr_q  <= '0;
            hcnt_q <= '0;
            busy_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            ptr_q  <= ptr_d;
            hcnt_q <= hcnt_d;
            busy_q <= busy_d;
        end
    end

    assign fb.in_ready = ready;
    assign fb.d_in     = out_q.d_in;
    assign fb.d_sel    = out_q.d_sel;
    assign fb.d_valid  = out_q.d_valid;
    assign fb.busy     = busy_q;

endmodule

// File: tb/tb_demux_feeder.sv
// Bench for demux_feeder: three instances (HOLD_CYCLES 1, 3, 4) checked each cycle
// against a cycles-remaining reference model, plus vector table and corner sequences.
module tb_demux_feeder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] mask [3];
    logic       vld  [3];
    logic       dat  [3];
    logic       rdy  [3];
    logic       ov   [3];
    logic       od   [3];
    logic [1:0] os   [3];
    logic       ob   [3];
    logic       pre_rdy [3];

    demux_feeder_if bus0 ();
    demux_feeder_if bus1 ();
    demux_feeder_if bus2 ();

    demux_feeder #(.HOLD_CYCLES(1)) u_h1 (.clk(clk), .reset(reset), .fb(bus0));
    demux_feeder #(.HOLD_CYCLES(3)) u_h3 (.clk(clk), .reset(reset), .fb(bus1));
    demux_feeder #(.HOLD_CYCLES(4)) u_h4 (.clk(clk), .reset(reset), .fb(bus2));

    assign bus0.en_mask = mask[0]; assign bus0.in_valid = vld[0]; assign bus0.in_data = dat[0];
    assign bus1.en_mask = mask[1]; assign bus1.in_valid = vld[1]; assign bus1.in_data = dat[1];
    assign bus2.en_mask = mask[2]; assign bus2.in_valid = vld[2]; assign bus2.in_data = dat[2];
    assign rdy[0] = bus0.in_ready; assign ov[0] = bus0.d_valid; assign od[0] = bus0.d_in;
    assign os[0]  = bus0.d_sel;    assign ob[0] = bus0.busy;
    assign rdy[1] = bus1.in_ready; assign ov[1] = bus1.d_valid; assign od[1] = bus1.d_in;
    assign os[1]  = bus1.d_sel;    assign ob[1] = bus1.busy;
    assign rdy[2] = bus2.in_ready; assign ov[2] = bus2.d_valid; assign od[2] = bus2.d_in;
    assign os[2]  = bus2.d_sel;    assign ob[2] = bus2.busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bit presented for 'left' more cycles, pointer as channel number.
    int m_left [3];
    int m_ptr  [3];
    int m_v    [3];
    int m_d    [3];
    int m_sel  [3];

    typedef struct {
        logic [3:0] mask;
        logic       valid;
        logic       data;
        logic       exp_ready;
        logic       exp_valid;
        logic       exp_din;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl [12];

    int h3_rdy [7] = '{1, 0, 0, 1, 0, 0, 1};
    int h3_vld [7] = '{1, 1, 1, 1, 1, 1, 0};
    int mc_rdy [4] = '{0, 0, 0, 1};
    int mc_sel [4] = '{2, 2, 2, 0};

    function automatic int hold_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int pick_ch(input int p, input logic [3:0] m);
        for (int k = 0; k < 4; k++) begin
            if (m[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic int m_ready(input int i);
        return ((mask[i] != 4'd0) && (m_left[i] <= 1)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_left[i] = 0; m_ptr[i] = 0; m_v[i] = 0; m_d[i] = 0; m_sel[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int acc);
        int c;
        if (acc != 0) begin
            c         = pick_ch(m_ptr[i], mask[i]);
            m_v[i]    = 1;
            m_d[i]    = int'(dat[i]);
            m_sel[i]  = c;
            m_ptr[i]  = (c + 1) % 4;
            m_left[i] = hold_of(i);
        end else begin
            if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) begin
                m_v[i] = 0;
                m_d[i] = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d, want %0d (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    // One clock: check ready before the edge, advance model, check outputs after.
    task automatic tick();
        int acc [3];
        #1;
        for (int i = 0; i < 3; i++) begin
            pre_rdy[i] = rdy[i];
            chk("in_ready", i, int'(rdy[i]), m_ready(i));
            acc[i] = (vld[i] && (m_ready(i) != 0)) ? 1 : 0;
        end
        for (int i = 0; i < 3; i++) model_step(i, acc[i]);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("d_valid", i, int'(ov[i]), m_v[i]);
            chk("d_in",    i, int'(od[i]), m_d[i]);
            chk("d_sel",   i, int'(os[i]), m_sel[i]);
            chk("busy",    i, int'(ob[i]), (hold_of(i) > 1 && m_left[i] > 0) ? 1 : 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mask[i] = 4'd0; vld[i] = 1'b0; dat[i] = 1'b0;
        end
        model_reset();

        tbl[0]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0};
        tbl[1]  = '{4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2};
        tbl[3]  = '{4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3};
        tbl[4]  = '{4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
        tbl[5]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3};
        tbl[6]  = '{4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
        tbl[7]  = '{4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3};
        tbl[8]  = '{4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1};
        tbl[9]  = '{4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
        tbl[10] = '{4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2};
        tbl[11] = '{4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset d_valid", i, int'(ov[i]), 0);
            chk("reset d_in",    i, int'(od[i]), 0);
            chk("reset d_sel",   i, int'(os[i]), 0);
            chk("reset busy",    i, int'(ob[i]), 0);
        end
        reset = 1'b0;

        // Vector table on the HOLD_CYCLES=1 instance.
        for (int k = 0; k < 12; k++) begin
            mask[0] = tbl[k].mask;
            vld[0]  = tbl[k].valid;
            dat[0]  = tbl[k].data;
            tick();
            chk("tbl ready", k, int'(pre_rdy[0]), int'(tbl[k].exp_ready));
            chk("tbl valid", k, int'(ov[0]), int'(tbl[k].exp_valid));
            chk("tbl d_in",  k, int'(od[0]), int'(tbl[k].exp_din));
            chk("tbl d_sel", k, int'(os[0]), int'(tbl[k].exp_sel));
        end
        vld[0] = 1'b0;

        // HOLD_CYCLES=3: two bits back to back, valid unbroken for 6 cycles.
        mask[1] = 4'hF;
        for (int k = 0; k < 7; k++) begin
            vld[1] = (k < 4);
            dat[1] = (k < 3);
            tick();
            chk("h3 ready seq", k, int'(pre_rdy[1]), h3_rdy[k]);
            chk("h3 valid seq", k, int'(ov[1]), h3_vld[k]);
            chk("h3 busy seq",  k, int'(ob[1]), h3_vld[k]);
            if (k == 0) chk("h3 first sel", k, int'(os[1]), 0);
            if (k == 3) chk("h3 second sel", k, int'(os[1]), 1);
            if (k == 3) chk("h3 second din", k, int'(od[1]), 0);
        end
        vld[1] = 1'b0;
        mask[1] = 4'h0;

        // HOLD_CYCLES=4: mask change mid-hold must not move the presented channel.
        mask[2] = 4'b0010; vld[2] = 1'b1; dat[2] = 1'b0;
        tick();
        chk("mc setup sel", 2, int'(os[2]), 1);
        vld[2] = 1'b0;
        repeat (4) tick();
        mask[2] = 4'hF; vld[2] = 1'b1; dat[2] = 1'b1;
        tick();
        chk("mc start sel", 2, int'(os[2]), 2);
        mask[2] = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mc ready seq", k, int'(pre_rdy[2]), mc_rdy[k]);
            chk("mc sel seq",   k, int'(os[2]), mc_sel[k]);
            chk("mc valid seq", k, int'(ov[2]), 1);
        end
        vld[2] = 1'b0;
        repeat (4) tick();
        chk("mc idle valid", 2, int'(ov[2]), 0);

        // Asynchronous reset between clock edges during a hold.
        mask[2] = 4'hF; vld[2] = 1'b1; dat[2] = 1'b1;
        tick();
        chk("ar pre busy", 2, int'(ob[2]), 1);
        chk("ar pre sel",  2, int'(os[2]), 1);
        vld[2] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar d_valid", 2, int'(ov[2]), 0);
        chk("ar d_in",    2, int'(od[2]), 0);
        chk("ar d_sel",   2, int'(os[2]), 0);
        chk("ar busy",    2, int'(ob[2]), 0);
        model_reset();
        #1;
        reset = 1'b0;
        vld[2] = 1'b1;
        tick();
        chk("ar post sel",   2, int'(os[2]), 0);
        chk("ar post valid", 2, int'(ov[2]), 1);
        vld[2] = 1'b0;

        // Randomized traffic on all three instances against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) mask[i] = 4'($urandom_range(0, 15));
                vld[i] = ($urandom_range(0, 3) != 0);
                dat[i] = 1'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
